// File: rtl/rate_div_pkg.sv
// Shared types, speed encodings and the load-length helper for the rate divider.
package rate_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] SPD_FULL = 2'b00;  // strobe every clock
    localparam logic [1:0] SPD_1HZ  = 2'b01;  // one strobe per F clocks
    localparam logic [1:0] SPD_HALF = 2'b10;  // one strobe per 2F clocks
    localparam logic [1:0] SPD_QTR  = 2'b11;  // one strobe per 4F clocks

    // Period in clocks for a given speed code, F = clocks per second.
    function automatic int unsigned load_len(input logic [1:0] speed, input int unsigned f);
        case (speed)
            SPD_FULL: return 1;
            SPD_1HZ:  return f;
            SPD_HALF: return 2 * f;
            default:  return 4 * f;
        endcase
    endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter that saturates at zero and flags when it has reached it.
module load_down_counter #(
    parameter int CW = 4
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          is_zero
);

    logic [CW-1:0] cnt;

    // Load takes priority over decrement; decrement stops at zero so it can never wrap.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign is_zero = (cnt == '0);

endmodule

// File: rtl/rate_divider_enable.sv
// Run/pause/clear controlled clock divider producing a registered one-cycle Enable strobe.
module rate_divider_enable
    import rate_div_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 50000000,
    parameter int          CW              = $clog2(4 * CLOCK_FREQUENCY)
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] Speed,
    input  logic       Go,
    input  logic       Hold,
    input  logic       Clear,
    output logic       Enable,
    output logic       Running
);

    state_t        state;
    state_t        state_n;
    logic [1:0]    spd_q;
    logic          spd_chg;
    logic          step;
    logic          cnt_zero;
    logic          ld;
    logic          dec;
    logic          en_n;
    logic [CW-1:0] ld_val;

    assign spd_chg = (Speed != spd_q);

    // When the speed is unchanged Speed equals spd_q, so one reload value serves
    // Go-from-IDLE, period wrap, Clear and speed-change reloads alike.
    assign ld_val = CW'(load_len(Speed, CLOCK_FREQUENCY) - 1);

    load_down_counter #(
        .CW(CW)
    ) u_cnt (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (ld),
        .load_val (ld_val),
        .dec      (dec),
        .is_zero  (cnt_zero)
    );

    // Next state, counter control and next Enable; Clear and speed change override last.
    always_comb begin
        state_n = state;
        ld      = 1'b0;
        dec     = 1'b0;
        en_n    = 1'b0;
        // A resume from PAUSE counts on the Go edge itself, so a pause of N cycles
        // stretches the current period by exactly N cycles.
        step    = ((state == RUN) && !Hold) || ((state == PAUSE) && Go && !Hold);

        case (state)
            IDLE: begin
                if (Go && !Hold) begin
                    state_n = RUN;
                    ld      = 1'b1;
                end
            end
            RUN: begin
                if (Hold) begin
                    state_n = PAUSE;
                end
            end
            PAUSE: begin
                if (Go && !Hold) begin
                    state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase

        if (step) begin
            if (cnt_zero) begin
                en_n = 1'b1;
                ld   = 1'b1;
            end else begin
                dec  = 1'b1;
            end
        end

        if (Clear) begin
            state_n = IDLE;
            ld      = 1'b1;
            dec     = 1'b0;
            en_n    = 1'b0;
        end

        if (spd_chg) begin
            ld   = 1'b1;
            dec  = 1'b0;
            en_n = 1'b0;
        end
    end

    // State, captured speed and the registered Enable strobe.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            spd_q  <= SPD_FULL;
            Enable <= 1'b0;
        end else begin
            state  <= state_n;
            spd_q  <= Speed;
            Enable <= en_n;
        end
    end

    assign Running = (state == RUN);

endmodule

// File: doc/rate_divider_enable.md
Name: rate_divider_enable

Overview:
Generates the one-cycle Enable strobe that drives the 8-bit T-flip-flop counter stage (Enable input, counts on Clock).
- Divides Clock by a Speed-selected ratio.
- Run/pause/clear control FSM, so the counter downstream advances at a human-visible rate (HEX/LED display) or at full clock rate.
- Enable is registered and glitch-free, and is always exactly one Clock cycle wide.

Parameters:
- CLOCK_FREQUENCY, 50000000: Clock cycles per second; the bench uses 4.
- CW, $clog2(4*CLOCK_FREQUENCY): down-counter width, derived; not overridden.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Speed  input  2  rate select: 00 = every cycle, 01 = 1 Hz, 10 = 0.5 Hz, 11 = 0.25 Hz.
- Go     input  1  level, sampled each edge: start from IDLE, resume from PAUSE.
- Hold   input  1  level: pause while RUN.
- Clear  input  1  level: return to IDLE and reload.
- Enable output 1  registered one-cycle strobe to the counter's Enable.
- Running output 1 high while FSM is in RUN.

Behaviour:
- Load length L(Speed): 00→1, 01→F, 10→2F, 11→4F, where F = CLOCK_FREQUENCY.
- Reset (Reset=0, async) forces:
  - state=IDLE, cnt=0, spd_q=00, Enable=0, Running=0.
  - Release is synchronous to the next edge.
- States: IDLE, RUN, PAUSE. Priority is Clear > Hold > Go.
  - Clear=1 (any state): next=IDLE, cnt<=L(spd_q)-1, Enable<=0.
  - IDLE: Go → RUN with cnt<=L-1. Hold alone has no effect.
  - RUN: Hold → PAUSE, cnt frozen, Enable<=0. Otherwise count (see below).
  - PAUSE: Go → RUN, resuming from the frozen cnt with no reload. Hold/Go both 1 → stay PAUSE.
- Counting in RUN:
  - If cnt==0: Enable<=1, cnt<=L-1.
  - Else: cnt<=cnt-1, Enable<=0.
  - With Go sampled at edge k, the first Enable is high in the cycle after edge k+L. Period is exactly L cycles, duty 1/L.
  - Speed 00: Enable is continuously high from edge k+1 while in RUN.
- Speed change:
  - Each edge compares Speed with spd_q. On mismatch (any state): spd_q<=Speed, cnt<=L(Speed)-1, Enable<=0. The FSM still transitions normally.
  - Speed-change reload overrides the RUN count and PAUSE freeze. Clear still wins over the state transition.
- Enable is never high outside RUN-derived cycles. It is 0 in the cycle after any Hold, Clear or Speed change.
- Running = (state==RUN), decoded from the state register, so it is glitch-free.
- cnt never underflows. Reload is always to L-1 ≤ 4F-1, which fits in CW bits.
- Reset asserted mid-period: Enable drops immediately (async). After release, Go is required again.

Decomposition:
- Package rate_div_pkg holds:
  - state_t enum {IDLE, RUN, PAUSE}.
  - Speed encodings SPD_FULL/SPD_1HZ/SPD_HALF/SPD_QTR.
  - Function load_len(speed, F) returning L.
- One sub-module, load_down_counter (CW-bit):
  - Ports: Clock, Reset, load, load_val, dec; output is_zero.
- The top contains the FSM, the speed-change detector and the Enable register.

Test Plan:
- F=4: reset, Speed=01, Go=1 one cycle at edge k → Enable high only in cycles after edges k+4, k+8, k+12; Running=1 from edge k.
- Speed=00, Go → Enable=1 every cycle from edge k+1; downstream 8-bit counter reaches 8'hFF after 255 cycles and wraps to 8'h00 at 256.
- Speed=10 (L=8), Hold at edge k+3 for 5 cycles, then Go → no Enable while paused; next Enable after edge k+3+5+5 (5 counts remain).
- Speed=11 running, change to 01 at edge j → Enable=0 after edge j, then next Enable after edge j+4.
- Clear+Hold+Go all high in RUN → IDLE, Running=0, Enable=0. Go alone next edge → first Enable L cycles later.
- Reset pulled low mid-period between edges → Enable and Running drop without a clock edge. After release, no Enable until Go.
